// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the stream sources, the arbiter and the async FIFO.
// master = source/FIFO environment, slave = arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int LOGIC_SIZE = 32
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*LOGIC_SIZE-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_wr;
  logic [LOGIC_SIZE-1:0]         o_wdata;
  logic                          i_wfull;
  logic [GW-1:0]                 o_grant;
  logic                          o_busy;
  logic                          o_trunc;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_wfull,
    input  o_req_ready, o_wr, o_wdata, o_grant, o_busy, o_trunc
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_wfull,
    output o_req_ready, o_wr, o_wdata, o_grant, o_busy, o_trunc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the async FIFO write port between
// NUM_REQ sources; a grant is held until last beat or the MAX_BEATS watchdog.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LOGIC_SIZE = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            trunc, trunc_nxt;

  logic [GW-1:0]   rr_pick;
  logic [GW-1:0]   idx;
  logic            any_valid;
  logic            xfer;
  logic [GW-1:0]   grant_inc;
  logic [LOGIC_SIZE-1:0] grant_data;

  // Downward scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    rr_pick   = rr_ptr;
    idx       = '0;
    any_valid = |bus.i_req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (bus.i_req_valid[idx]) rr_pick = idx;
    end
  end

  assign grant_data = bus.i_req_data[int'(grant)*LOGIC_SIZE +: LOGIC_SIZE];
  assign grant_inc  = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign xfer       = (state == BUSY) && bus.i_req_valid[grant] && !bus.i_wfull && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      trunc    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      trunc    <= trunc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    trunc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = BUSY;
          grant_nxt = rr_pick;
        end
      end
      BUSY: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          // Last beat takes precedence over the watchdog on the same beat.
          if (bus.i_req_last[grant]) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = grant_inc;
            beat_cnt_nxt = '0;
          end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = grant_inc;
            beat_cnt_nxt = '0;
            trunc_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready = '0;
    if ((state == BUSY) && !bus.i_wfull && !i_rst) bus.o_req_ready[grant] = 1'b1;
    bus.o_wr    = xfer;
    bus.o_wdata = (state == BUSY) ? grant_data : '0;
    bus.o_grant = grant;
    bus.o_busy  = (state == BUSY);
    bus.o_trunc = trunc;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a packet-level ownership model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .LOGIC_SIZE(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .LOGIC_SIZE(W), .MAX_BEATS(MB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // source generators
  int          len  [N];
  int          beat [N];
  int          pkt  [N];
  logic [N-1:0] xfer;
  logic        rst_seen;
  logic [N-1:0] mask;
  int          vprob, fprob, lmin, lmax;
  logic        rst_cmd;
  bit          chk_en;

  // reference model: who owns the FIFO, where the next search starts, beats taken
  bit m_busy;
  int m_owner, m_ptr, m_cnt;
  bit m_trunc;

  logic [W-1:0] wlog [$];
  int           trunc_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [W-1:0] e_data;
    bit           found;
    e_wr    = m_busy && bus.i_req_valid[m_owner] && !bus.i_wfull && !rst;
    e_ready = (m_busy && !bus.i_wfull && !rst) ? (N'(1) << m_owner) : '0;
    e_data  = m_busy ? bus.i_req_data[m_owner*W +: W] : '0;
    if (chk_en) begin
      chk("ready", bus.o_req_ready, e_ready);
      chk("wr",    bus.o_wr,        e_wr);
      chk("wdata", bus.o_wdata,     e_data);
      chk("busy",  bus.o_busy,      m_busy);
      chk("grant", bus.o_grant,     64'(m_owner));
      chk("trunc", bus.o_trunc,     m_trunc);
    end
    xfer     = bus.i_req_valid & bus.o_req_ready;
    rst_seen = rst;
    if (bus.o_wr === 1'b1) wlog.push_back(bus.o_wdata);
    if (bus.o_trunc === 1'b1) trunc_cnt++;

    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_trunc = 0;
    end else if (!m_busy) begin
      m_trunc = 0;
      found   = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && bus.i_req_valid[(m_ptr + i) % N]) begin
          found   = 1;
          m_owner = (m_ptr + i) % N;
          m_busy  = 1;
        end
      end
    end else begin
      m_trunc = 0;
      if (e_wr) begin
        m_cnt++;
        if (bus.i_req_last[m_owner]) begin
          m_busy = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
        end else if (m_cnt == MB) begin
          m_busy = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0; m_trunc = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (rst_seen) begin
        beat[k] = 0; pkt[k]++; len[k] = int'($urandom_range(lmax, lmin));
      end else if (xfer[k]) begin
        beat[k]++;
        if (beat[k] == len[k]) begin
          beat[k] = 0; pkt[k]++; len[k] = int'($urandom_range(lmax, lmin));
        end
      end
      bus.i_req_valid[k]        = mask[k] && (int'($urandom_range(0, 99)) < vprob);
      bus.i_req_data[k*W +: W]  = {8'(k), 8'(pkt[k]), 16'(beat[k])};
      bus.i_req_last[k]         = (beat[k] == len[k] - 1);
    end
    bus.i_wfull = (int'($urandom_range(0, 99)) < fprob);
    rst = rst_cmd;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic start_phase(input logic [N-1:0] m, input int vp, input int fp,
                             input int lo, input int hi);
    mask = m; vprob = vp; fprob = fp; lmin = lo; lmax = hi;
    rst_cmd = 1'b1;
    step();
    step();
    rst_cmd = 1'b0;
    wlog.delete();
    trunc_cnt = 0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_wfull     = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_trunc = 0;
    xfer = '0; rst_seen = 1'b1; trunc_cnt = 0;
    for (int k = 0; k < N; k++) begin len[k] = 3; beat[k] = 0; pkt[k] = 0; end
    mask = '1; vprob = 100; fprob = 0; lmin = 3; lmax = 3; rst_cmd = 1'b1; chk_en = 0;
    step();
    chk_en = 1;

    // all sources valid through reset, then 3-beat packets rotating 0..3
    start_phase(4'hF, 100, 0, 3, 3);
    chk("rst_busy",  bus.o_busy,      0);
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_wr",    bus.o_wr,        0);
    step();
    chk("p1_grant0", bus.o_grant, 0);
    step();
    chk("p1_ready0", bus.o_req_ready, 4'b0001);
    repeat (28) step();
    chk("p1_count", 64'(wlog.size() >= 12), 1);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog.size()) begin
        chk("p1_src",  wlog[i][31:24], 64'(i / 3));
        chk("p1_beat", wlog[i][15:0],  64'(i % 3));
      end
    end

    // watchdog: source 2 sends a 20-beat packet
    start_phase(4'b0100, 100, 0, 20, 20);
    repeat (30) step();
    chk("p2_trunc", trunc_cnt, 1);
    chk("p2_count", 64'(wlog.size() >= 20), 1);
    if (wlog.size() >= 20) begin
      chk("p2_b16",   wlog[16][15:0],  16);
      chk("p2_b19",   wlog[19][15:0],  19);
      chk("p2_samep", wlog[19][23:16], wlog[0][23:16]);
    end

    // full stall mid-packet on source 1
    start_phase(4'b0010, 100, 0, 4, 4);
    repeat (3) step();
    fprob = 100;
    repeat (5) begin
      step();
      chk("p3_stall_wr",    bus.o_wr,        0);
      chk("p3_stall_ready", bus.o_req_ready, 0);
    end
    fprob = 0;
    repeat (6) step();
    chk("p3_count", 64'(wlog.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) chk("p3_beat", wlog[i][15:0], 64'(i));

    // lone source 3, then source 0 competes and wins on the pointer
    start_phase(4'b1000, 100, 0, 8, 8);
    repeat (9) step();
    mask = 4'b1001;
    repeat (12) step();
    chk("p4_count", 64'(wlog.size() >= 9), 1);
    if (wlog.size() >= 9) begin
      chk("p4_last3", wlog[7][31:24], 3);
      chk("p4_b7",    wlog[7][15:0],  7);
      chk("p4_next0", wlog[8][31:24], 0);
    end

    // reset after the second beat of a 5-beat packet
    start_phase(4'b0001, 100, 0, 5, 5);
    guard = 0;
    while (wlog.size() < 2 && guard < 20) begin
      step();
      guard++;
    end
    chk("p5_wait", 64'(guard < 20), 1);
    rst_cmd = 1'b1;
    step();
    chk("p5_rst_wr", bus.o_wr, 0);
    rst_cmd = 1'b0;
    step();
    chk("p5_writes", wlog.size(), 2);
    chk("p5_idle",   bus.o_busy, 0);

    // long random run with backpressure, bubbles and occasional resets
    start_phase(4'hF, 70, 25, 1, 24);
    repeat (3000) begin
      rst_cmd = (int'($urandom_range(0, 999)) < 3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single write port of the async_fifo between NUM_REQ stream sources in the write-clock domain.
- Holds a grant until the granted source's last beat (or a beat-count watchdog), so packets never interleave in the FIFO.
- Drives the FIFO write request and data and obeys its full flag; sits directly upstream of the async_fifo write side in the SERDES TX path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOGIC_SIZE, 32, data width per beat; equals the FIFO data width.
- MAX_BEATS, 16, watchdog limit: maximum beats per grant before forced release (>=2).

Ports:
- i_clk  in  1  write-domain clock; same clock as the FIFO write clock. One clock only.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-source beat valid.
- i_req_data  in  NUM_REQ*LOGIC_SIZE  per-source data; source k occupies bits [k*LOGIC_SIZE +: LOGIC_SIZE].
- i_req_last  in  NUM_REQ  per-source last-beat-of-packet flag.
- o_req_ready  out  NUM_REQ  per-source ready; a beat transfers when valid && ready on the rising edge of i_clk.
- o_wr  out  1  FIFO write request.
- o_wdata  out  LOGIC_SIZE  FIFO write data.
- i_wfull  in  1  FIFO full flag.
- o_grant  out  $clog2(NUM_REQ)  index of the current owner.
- o_busy  out  1  a grant is active.
- o_trunc  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (i_rst high at a clock edge):
  - State goes to IDLE; rr_ptr=0; grant=0; beat_cnt=0; o_trunc=0.
  - While i_rst is high, o_req_ready=0 and o_wr=0, combinationally gated.
  - Reset mid-packet abandons the packet; no further beats are taken.
- States: IDLE and BUSY.
- IDLE:
  - o_busy=0, all o_req_ready=0, o_wr=0.
  - If any i_req_valid is set, select the first valid index searching upward from rr_ptr, with wrap-around mod NUM_REQ.
  - Register that index as grant and go to BUSY on the next edge. Grant latency is 1 cycle from valid to ready.
  - If no source is valid, stay in IDLE.
- BUSY:
  - o_busy=1.
  - o_req_ready[grant] = !i_wfull; all other readies are 0.
  - o_wr = i_req_valid[grant] && !i_wfull, combinational, with no added latency, so a write is never issued while the FIFO is full.
  - o_wdata = i_req_data[grant] at all times in BUSY; o_wdata=0 in IDLE.
  - Each transferred beat increments beat_cnt.
- Release conditions, evaluated on a transferred beat:
  - i_req_last[grant]=1: go to IDLE; rr_ptr = grant+1 mod NUM_REQ; beat_cnt=0.
  - Otherwise beat_cnt reaches MAX_BEATS: same release, and o_trunc=1 for exactly the following cycle.
  - If last and the watchdog occur on the same beat, last wins and o_trunc stays 0.
- Release always passes through IDLE for one cycle, so there is one bubble cycle between packets.
- Full flag:
  - i_wfull stalls the grant indefinitely with no transfer and no beat count.
  - The grant is never released because of backpressure.
- A source dropping valid mid-packet keeps the grant (bubble); no timeout on idle cycles.
- Fairness: a source that just released has lowest priority next round. With all sources continuously valid, grants rotate 0,1,2,3,0,…
- o_grant holds its last value in IDLE.

Test Plan:
- Reset with all valid=1 and i_wfull=0 -> o_wr=0, o_busy=0 and all ready=0 during reset. First cycle after release of reset: grant=0. Next cycle: o_req_ready=4'b0001.
- All 4 sources continuously send 3-beat packets (last on beat 3), data = {source, beat} -> FIFO receives 12 beats in order src0,src1,src2,src3. Each packet is contiguous. One idle cycle between packets.
- Source 2 holds last=0 for 20 beats -> release after beat 16, o_trunc pulses once, next grant goes to source 3 (if valid) or wraps around; beats 17-20 go out under a later grant.
- i_wfull=1 for 5 cycles in the middle of a 4-beat packet from source 1 -> o_wr=0 and ready=0 for those 5 cycles. The packet resumes intact with no beat lost or duplicated. beat_cnt is unchanged during the stall.
- Only source 3 is valid, with an 8-beat packet -> grant=3 after 1 cycle, 8 consecutive writes, then back to IDLE. A following request from source 0 gets the grant ahead of a simultaneous request from source 3.
- i_rst asserted on beat 2 of a 5-beat packet -> o_wr=0 in the reset cycle. State returns to IDLE with rr_ptr=0. Exactly 2 beats were written to the FIFO.
